// File: rtl/queue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : queue_arbiter                                                 |
// | Purpose  : Round-robin arbiter feeding one registered output slot that   |
// |            drives a downstream queue enqueue port (valid/ready).         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module queue_arbiter #(
  parameter int W     = 32,
  parameter int N_REQ = 4,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [N_REQ-1:0]   req_v,
  output logic [N_REQ-1:0]   req_rdy,
  input  logic [N_REQ*W-1:0] req,
  output logic               o_v,
  input  logic               o_rdy,
  output logic [W-1:0]       o,
  output logic [IDW-1:0]     o_id
);

  localparam logic [IDW-1:0] c_LAST_ID = IDW'(N_REQ - 1);

  logic [W-1:0]   w_req_arr [N_REQ];
  logic [IDW-1:0] r_ptr;
  logic           w_found;
  logic [IDW-1:0] w_gnt;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_can_acc;
  logic           w_accept;
  int             w_dist;
  int             w_best;

  // Split the flat payload bus into one word per requester.
  generate
    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign w_req_arr[k] = req[k*W +: W];
    end
  endgenerate

  // Pick the valid requester at the smallest rotational distance from the
  // priority pointer; this is the ptr, ptr+1, ... wrap-around scan.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_best  = N_REQ;
    w_dist  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_dist = k - int'(r_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + N_REQ;
      end
      if (req_v[k] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_gnt   = IDW'(k);
        w_found = 1'b1;
      end
    end
  end

  // The slot can take a new item when it is empty or draining this cycle;
  // rst is folded in so no grant is advertised while reset is held.
  assign w_can_acc = clk_en && !rst && (!o_v || o_rdy);
  assign w_accept  = w_found && w_can_acc;
  assign w_ptr_nxt = (w_gnt == c_LAST_ID) ? '0 : w_gnt + IDW'(1);

  // One-hot ready towards the winner only; independent of payload.
  always_comb begin
    req_rdy = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_rdy[k] = w_accept && (w_gnt == IDW'(k));
    end
  end

  // Output slot and priority pointer; a grant overrides a drain so the slot
  // is refilled in the same cycle it empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_v   <= 1'b0;
      o     <= '0;
      o_id  <= '0;
      r_ptr <= '0;
    end else if (clk_en) begin
      if (w_found && (!o_v || o_rdy)) begin
        o     <= w_req_arr[w_gnt];
        o_id  <= w_gnt;
        o_v   <= 1'b1;
        r_ptr <= w_ptr_nxt;
      end else if (o_v && o_rdy) begin
        o_v <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_queue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_queue_arbiter                                              |
// | Purpose  : Scoreboard bench for queue_arbiter (N_REQ=4 and N_REQ=3).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_queue_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           clk_en;
  logic [N-1:0]   req_v;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req;
  logic           o_v;
  logic           o_rdy;
  logic [W-1:0]   o;
  logic [1:0]     o_id;

  logic            clk_en3;
  logic [N3-1:0]   req_v3;
  logic [N3-1:0]   req_rdy3;
  logic [N3*W-1:0] req3;
  logic            o_v3;
  logic            o_rdy3;
  logic [W-1:0]    o3;
  logic [1:0]      o_id3;

  queue_arbiter #(.W(W), .N_REQ(N)) u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_v(req_v), .req_rdy(req_rdy),
    .req(req), .o_v(o_v), .o_rdy(o_rdy), .o(o), .o_id(o_id)
  );

  queue_arbiter #(.W(W), .N_REQ(N3)) u_dut3 (
    .clk(clk), .rst(rst), .clk_en(clk_en3), .req_v(req_v3), .req_rdy(req_rdy3),
    .req(req3), .o_v(o_v3), .o_rdy(o_rdy3), .o(o3), .o_id(o_id3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } item_t;

  item_t exp_q[$];
  item_t exp3_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot occupancy plus a rotating priority index.
  int mptr;
  bit mov;
  always @(negedge clk) begin : model
    int           winner;
    bit           can;
    logic [N-1:0] er;
    int           kk;
    if (rst) begin
      mptr = 0;
      mov  = 0;
      exp_q.delete();
      check("rdy_in_reset", 64'(req_rdy), 64'(0));
    end else begin
      can    = clk_en && (!mov || o_rdy);
      winner = -1;
      for (int s = 0; s < N; s++) begin
        kk = (mptr + s) % N;
        if (winner < 0 && req_v[kk]) winner = kk;
      end
      er = '0;
      if (can && winner >= 0) er[winner] = 1'b1;
      check("req_rdy", 64'(req_rdy), 64'(er));
      check("o_v", 64'(o_v), 64'(mov));
      if (can && winner >= 0) begin
        exp_q.push_back('{winner, req[winner*W +: W]});
        mptr = (winner + 1) % N;
        mov  = 1;
      end else if (clk_en && mov && o_rdy) begin
        mov = 0;
      end
    end
  end

  // Output monitor: pops on each completed output handshake and checks that
  // a stalled or disabled slot does not move.
  bit           hold;
  logic         h_ov;
  logic [W-1:0] h_o;
  logic [1:0]   h_id;
  always @(negedge clk) begin : monitor
    item_t e;
    if (rst) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_o_v", 64'(o_v), 64'(h_ov));
        check("hold_o", 64'(o), 64'(h_o));
        check("hold_o_id", 64'(o_id), 64'(h_id));
      end
      if (clk_en && o_v && o_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got id %0d data 0x%0h expected nothing", o_id, o);
        end else begin
          e = exp_q.pop_front();
          check("o_id", 64'(o_id), 64'(e.id));
          check("o", 64'(o), 64'(e.data));
        end
      end
      hold = !clk_en || (o_v && !o_rdy);
      h_ov = o_v;
      h_o  = o;
      h_id = o_id;
    end
  end

  // Monitor for the three-requester instance.
  int got3 = 0;
  int cnt_id3 [N3];
  always @(negedge clk) begin : monitor3
    item_t e;
    if (!rst && o_v3 && o_rdy3) begin
      if (exp3_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL n3_unexpected: got id %0d data 0x%0h expected nothing", o_id3, o3);
      end else begin
        e = exp3_q.pop_front();
        check("n3_o_id", 64'(o_id3), 64'(e.id));
        check("n3_o", 64'(o3), 64'(e.data));
      end
      got3++;
      if (int'(o_id3) < N3) cnt_id3[o_id3]++;
    end
  end

  // Requester driver: handshakes sampled before the edge, new items offered
  // just after it; an item stays put until its handshake completes.
  logic [W-1:0] next_pay;
  int           p_new;
  logic [N-1:0] mask;
  logic [N-1:0] last_hs;

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_v & req_rdy;
    last_hs = hs;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (hs[k]) req_v[k] = 1'b0;
      if (mask[k] && !req_v[k] && ($urandom_range(99) < p_new)) begin
        req_v[k]       = 1'b1;
        req[k*W +: W]  = next_pay;
        next_pay       = next_pay + 1;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_o_v"}, 64'(o_v), 64'(0));
    check({tag, "_o"}, 64'(o), 64'(0));
    check({tag, "_o_id"}, 64'(o_id), 64'(0));
    check({tag, "_req_rdy"}, 64'(req_rdy), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int cnt3 [N3];

  task automatic step3();
    logic [N3-1:0] hs;
    @(negedge clk);
    hs = req_v3 & req_rdy3;
    @(posedge clk);
    #1;
    for (int k = 0; k < N3; k++) begin
      if (hs[k]) begin
        cnt3[k]++;
        if (cnt3[k] >= 3) req_v3[k] = 1'b0;
        else req3[k*W +: W] = W'((k << 8) | cnt3[k]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    clk_en   = 1'b1;
    o_rdy    = 1'b0;
    req_v    = '1;
    req      = '0;
    mask     = '0;
    p_new    = 0;
    next_pay = '0;
    last_hs  = '0;
    clk_en3  = 1'b1;
    req_v3   = '0;
    req3     = '0;
    o_rdy3   = 1'b1;
    for (int k = 0; k < N3; k++) begin
      cnt3[k]    = 0;
      cnt_id3[k] = 0;
    end

    // Reset state with requests pending.
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_v", 64'(o_v), 64'(0));
    check("rst_o", 64'(o), 64'(0));
    check("rst_o_id", 64'(o_id), 64'(0));
    check("rst_req_rdy", 64'(req_rdy), 64'(0));
    req_v = '0;
    rst   = 1'b0;

    // All requesting, downstream always ready: one item per cycle.
    for (int k = 0; k < N; k++) req[k*W +: W] = W'(32'h10 + k);
    req_v    = '1;
    next_pay = 32'h14;
    mask     = '1;
    p_new    = 100;
    o_rdy    = 1'b1;
    repeat (8) step();
    check("throughput_items", 64'(next_pay), 64'(32'h1C));
    mask = '0;
    repeat (6) step();

    // Wrap-around: park the pointer at 3 via req 2, then offer 1 and 2.
    do_reset("rst2");
    req_v = '0;
    mask  = 4'b0100;
    step();
    step();
    mask = 4'b0110;
    step();
    step();
    check("wrap_first", 64'(last_hs), 64'(4'b0010));
    step();
    check("wrap_second", 64'(last_hs), 64'(4'b0100));
    mask = '0;
    repeat (4) step();

    // Stall with req 0 waiting, then drain and accept in the same cycle.
    o_rdy = 1'b0;
    mask  = 4'b0001;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_no_grant", 64'(last_hs), 64'(0));
    end
    o_rdy = 1'b1;
    step();
    check("drain_accept", 64'(last_hs), 64'(4'b0001));

    // Clock enable low with traffic pending.
    mask = '1;
    repeat (3) step();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("clk_en_no_hs", 64'(last_hs), 64'(0));
    end
    clk_en = 1'b1;
    step();
    check("resume_grant", 64'(|last_hs), 64'(1));

    // Reset in the middle of a stall; first grant afterwards is req 0.
    o_rdy = 1'b0;
    repeat (3) step();
    do_reset("rst_stall");
    o_rdy = 1'b1;
    step();
    check("after_reset_grant0", 64'(last_hs), 64'(4'b0001));

    // Randomized traffic.
    p_new = 40;
    for (int i = 0; i < 1500; i++) begin
      o_rdy  = ($urandom_range(3) != 0);
      clk_en = ($urandom_range(9) != 0);
      step();
    end

    // Drain everything.
    mask   = '0;
    clk_en = 1'b1;
    o_rdy  = 1'b1;
    repeat (12) step();
    check("final_req_v", 64'(req_v), 64'(0));
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_o_v", 64'(o_v), 64'(0));

    // Three requesters, all requesting, nine items.
    for (int n = 0; n < 9; n++) begin
      exp3_q.push_back('{n % N3, W'(((n % N3) << 8) | (n / N3))});
    end
    for (int k = 0; k < N3; k++) req3[k*W +: W] = W'(k << 8);
    req_v3 = '1;
    for (int c = 0; c < 40 && got3 < 9; c++) step3();
    repeat (3) @(posedge clk);
    #1;
    check("n3_items", 64'(got3), 64'(9));
    for (int k = 0; k < N3; k++) check("n3_per_id", 64'(cnt_id3[k]), 64'(3));
    check("n3_queue_empty", 64'(exp3_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
